// File: rtl/jtag_debug_cmd_sync.sv
// rtl/jtag_debug_cmd_sync.sv - CPU-clock side of the JTAG debug command path
// Synchronises TCK-domain update toggles, queues {ir, sr} commands and issues per-channel action pulses.
module jtag_debug_cmd_sync #(
  parameter int DATA_W      = 38,
  parameter int IR_W        = 2,
  parameter int NUM_CH      = 4,
  parameter int ACT_BIT     = 35,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          upd_toggle,
  input  logic [DATA_W-1:0]             sr,
  input  logic [IR_W-1:0]               ir_in,
  input  logic                          cmd_ready,
  input  logic                          ovf_clr,
  output logic [DATA_W-1:0]             jdo,
  output logic [NUM_CH-1:0]             take_action,
  output logic [NUM_CH-1:0]             take_no_action,
  output logic                          bad_ir,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = IR_W + DATA_W;
  localparam int ARM_N = SYNC_STAGES + 1;
  localparam int ARM_W = $clog2(ARM_N + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q;
  logic [ARM_W-1:0]       arm_cnt_q, arm_cnt_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic [ENT_W-1:0]       mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]      jdo_q, jdo_d;
  logic [NUM_CH-1:0]      ta_q, ta_d, tna_q, tna_d, onehot;
  logic                   bad_q, bad_d, ovf_q, ovf_d;
  logic                   armed, upd_edge, empty, full, push, pop, drop;
  logic [DATA_W-1:0]      head_sr;
  logic [IR_W-1:0]        head_ir;

  assign head_sr = mem_q[rd_ptr_q][DATA_W-1:0];
  assign head_ir = mem_q[rd_ptr_q][ENT_W-1:DATA_W];

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], upd_toggle};
    // Edges are suppressed until the synchroniser has flushed its post-reset contents.
    armed     = (arm_cnt_q == ARM_W'(ARM_N));
    arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + ARM_W'(1);
    upd_edge  = armed & (sync_q[SYNC_STAGES-1] ^ prev_q);

    empty = (level_q == '0);
    full  = (level_q == LVL_W'(FIFO_DEPTH));
    pop   = ~empty & cmd_ready;
    push  = upd_edge & (~full | pop);
    drop  = upd_edge & full & ~pop;

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;

    onehot = '0;
    for (int i = 0; i < NUM_CH; i++) onehot[i] = (head_ir == IR_W'(i));

    jdo_d = jdo_q;
    ta_d  = '0;
    tna_d = '0;
    bad_d = 1'b0;
    if (pop) begin
      jdo_d = head_sr;
      if ({1'b0, head_ir} < (IR_W+1)'(NUM_CH)) begin
        if (head_sr[ACT_BIT]) ta_d  = onehot;
        else                  tna_d = onehot;
      end else begin
        bad_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      prev_q    <= 1'b0;
      arm_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      jdo_q     <= '0;
      ta_q      <= '0;
      tna_q     <= '0;
      bad_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= sync_q[SYNC_STAGES-1];
      arm_cnt_q <= arm_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      jdo_q     <= jdo_d;
      ta_q      <= ta_d;
      tna_q     <= tna_d;
      bad_q     <= bad_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {ir_in, sr};
  end

  assign jdo            = jdo_q;
  assign take_action    = ta_q;
  assign take_no_action = tna_q;
  assign bad_ir         = bad_q;
  assign fifo_level     = level_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_jtag_debug_cmd_sync.sv
// tb/tb_jtag_debug_cmd_sync.sv - scoreboard bench for jtag_debug_cmd_sync
module tb_jtag_debug_cmd_sync;

  typedef struct packed {
    logic [3:0]  ta;
    logic [3:0]  tna;
    logic        bad;
    logic [37:0] jdo;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        upd = 1'b0, ready = 1'b0, clr = 1'b0;
  logic [37:0] sr = '0;
  logic [1:0]  ir = '0;
  logic [37:0] jdo;
  logic [3:0]  ta, tna;
  logic        bad, ovf;
  logic [2:0]  lvl;

  logic        upd3 = 1'b0, ready3 = 1'b1;
  logic [37:0] sr3 = '0;
  logic [1:0]  ir3 = '0;
  logic [37:0] jdo3;
  logic [2:0]  ta3, tna3;
  logic        bad3, ovf3;
  logic [2:0]  lvl3;

  jtag_debug_cmd_sync dut (
    .clk(clk), .reset(rst), .upd_toggle(upd), .sr(sr), .ir_in(ir), .cmd_ready(ready),
    .ovf_clr(clr), .jdo(jdo), .take_action(ta), .take_no_action(tna), .bad_ir(bad),
    .fifo_level(lvl), .overflow(ovf)
  );

  jtag_debug_cmd_sync #(.NUM_CH(3)) dut3 (
    .clk(clk), .reset(rst), .upd_toggle(upd3), .sr(sr3), .ir_in(ir3), .cmd_ready(ready3),
    .ovf_clr(1'b0), .jdo(jdo3), .take_action(ta3), .take_no_action(tna3), .bad_ir(bad3),
    .fifo_level(lvl3), .overflow(ovf3)
  );

  int n_checks = 0;
  int n_pass   = 0;
  exp_t exp_q[$];
  exp_t exp3_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  function automatic exp_t model(input logic [1:0] i, input logic [37:0] d, input int nch);
    exp_t e;
    e = '0;
    e.jdo = d;
    if (int'(i) < nch) begin
      if (d[35]) e.ta[i] = 1'b1;
      else       e.tna[i] = 1'b1;
    end else begin
      e.bad = 1'b1;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && (|ta || |tna || bad)) begin
      if (exp_q.size() == 0) check("unexpected_pulse", 1, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ta", ta, e.ta);
        check("tna", tna, e.tna);
        check("bad", bad, e.bad);
        check("jdo", jdo, e.jdo);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && (|ta3 || |tna3 || bad3)) begin
      if (exp3_q.size() == 0) check("unexpected_pulse3", 1, 0);
      else begin
        exp_t e;
        e = exp3_q.pop_front();
        check("ta3", {1'b0, ta3}, e.ta);
        check("tna3", {1'b0, tna3}, e.tna);
        check("bad3", bad3, e.bad);
        check("jdo3", jdo3, e.jdo);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] i, input logic [37:0] d, input bit keep);
    ir  = i;
    sr  = d;
    upd = ~upd;
    if (keep) exp_q.push_back(model(i, d, 4));
  endtask

  task automatic send3(input logic [1:0] i, input logic [37:0] d);
    ir3  = i;
    sr3  = d;
    upd3 = ~upd3;
    exp3_q.push_back(model(i, d, 3));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && (exp_q.size() != 0 || exp3_q.size() != 0); i++) @(posedge clk);
    #1;
    check("drain", exp_q.size() + exp3_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick(2);
    @(negedge clk);
    check("rst_jdo", jdo, 0);
    check("rst_ta", ta, 0);
    check("rst_tna", tna, 0);
    check("rst_bad", bad, 0);
    check("rst_lvl", lvl, 0);
    check("rst_ovf", ovf, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ready = 1'b1;
    tick(6);

    // Single action command with exact latency
    send(2'd1, 38'h0A_1234_5678, 1);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("lat_ta_e%0d", k), ta, (k == 4) ? 4'b0010 : 4'b0000);
      if (k == 3) check("lat_lvl_e3", lvl, 1);
      if (k == 4) check("lat_lvl_e4", lvl, 0);
    end
    check("jdo_hold", jdo, 38'h0A_1234_5678);
    @(posedge clk); #1;

    send(2'd3, 38'h01_DEAD_BEEF, 1);
    wait_drain();

    // Backpressure, overflow, in-order burst release
    ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      send(2'(n), 38'(n * 38'h111) | (n[0] ? 38'h08_0000_0000 : 38'h0), n < 4);
      tick(3);
    end
    tick(2);
    check("bp_lvl", lvl, 4);
    check("bp_ovf", ovf, 1);
    ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("burst_%0d", k), (|ta || |tna), k < 4);
    end
    @(posedge clk); #1;
    check("ovf_sticky", ovf, 1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("ovf_clr", ovf, 0);

    // Overflow set beats a simultaneous clear; then push+pop while full
    ready = 1'b0;
    for (int n = 0; n < 4; n++) begin
      send(2'(3 - n), 38'h08_0000_0100 + 38'(n), 1);
      tick(3);
    end
    check("full_no_ovf", ovf, 0);
    send(2'd0, 38'h3F_FFFF_FFFF, 0);
    tick(2);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("set_wins", ovf, 1);
    send(2'd2, 38'h00_0000_0ABC, 1);
    tick(2);
    ready = 1'b1;
    tick(1);
    check("full_pushpop_lvl", lvl, 4);
    wait_drain();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;

    // Out-of-range IR on a 3-channel instance
    send3(2'd3, 38'h08_5555_AAAA);
    tick(3);
    send3(2'd2, 38'h08_0000_0001);
    wait_drain();
    check("bad3_jdo", jdo3, 38'h08_0000_0001);

    // Toggle held high through reset release must not create a command
    rst = 1'b1;
    upd = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(10);
    check("guard_lvl", lvl, 0);
    check("guard_none", exp_q.size(), 0);
    send(2'd2, 38'h08_CAFE_0000, 1);
    wait_drain();
    tick(6);

    // Reset with commands queued discards them
    ready = 1'b0;
    send(2'd0, 38'h08_0000_0011, 0);
    tick(3);
    send(2'd1, 38'h00_0000_0022, 0);
    tick(4);
    check("mid_lvl", lvl, 2);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_lvl", lvl, 0);
    check("mid_rst_jdo", jdo, 0);
    check("mid_rst_pulse", {ta, tna, bad}, 0);
    tick(2);
    rst = 1'b0;
    ready = 1'b1;
    tick(12);
    check("post_rst_lvl", lvl, 0);
    check("post_rst_ovf", ovf, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
